// File: rtl/ensemble_pkg.sv
// Shared types and constants for the three-classifier vote collector.
// The output beat carries the winning label in the low bits and an agreement mask above it.
package ensemble_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    OUT     = 1'b1
  } state_t;

  localparam int MASK_LSB   = 16;
  localparam int MASK_WIDTH = 3;
  localparam int NUM_CLF    = 3;

  function automatic logic all_equal3(input logic a, input logic b, input logic c);
    return (a == b) && (b == c);
  endfunction

endpackage

// File: rtl/majority3_voter.sv
// Combinational 2-of-3 majority vote over three class labels.
// Emits the winning label and a mask of which classifiers agreed with it.
module majority3_voter
  import ensemble_pkg::*;
#(
  parameter int CLASS_WIDTH = 8,
  parameter int TIE_SRC     = 0
) (
  input  logic [CLASS_WIDTH-1:0] label_0,
  input  logic [CLASS_WIDTH-1:0] label_1,
  input  logic [CLASS_WIDTH-1:0] label_2,
  output logic [CLASS_WIDTH-1:0] winner,
  output logic [MASK_WIDTH-1:0]  mask
);

  logic [CLASS_WIDTH-1:0] tie_label;

  assign tie_label = (TIE_SRC == 2) ? label_2 :
                     (TIE_SRC == 1) ? label_1 : label_0;

  always_comb begin
    winner = tie_label;
    if ((label_0 == label_1) || (label_0 == label_2)) begin
      winner = label_0;
    end else if (label_1 == label_2) begin
      winner = label_1;
    end
    mask = {(label_2 == winner), (label_1 == winner), (label_0 == winner)};
  end

endmodule

// File: rtl/ensemble_vote_collector.sv
// Collects one result beat from each of three classifiers into 1-entry slots and
// emits a majority-voted beat on an AXI-Stream master once all three slots are full.
module ensemble_vote_collector
  import ensemble_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int CLASS_WIDTH = 8,
  parameter int TIE_SRC     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
  input  logic                  s_axis_tvalid_0,
  input  logic                  s_axis_tlast_0,
  output logic                  s_axis_tready_0,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
  input  logic                  s_axis_tvalid_1,
  input  logic                  s_axis_tlast_1,
  output logic                  s_axis_tready_1,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
  input  logic                  s_axis_tvalid_2,
  input  logic                  s_axis_tlast_2,
  output logic                  s_axis_tready_2,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  tlast_mismatch,
  output logic [31:0]           vote_count
);

  logic [NUM_CLF-1:0][CLASS_WIDTH-1:0] in_label;
  logic [NUM_CLF-1:0]                  in_valid;
  logic [NUM_CLF-1:0]                  in_last;
  logic [NUM_CLF-1:0]                  slot_ready;
  logic [NUM_CLF-1:0]                  accept;

  state_t                              state_q, state_d;
  logic [NUM_CLF-1:0]                  held_q, held_d;
  logic [NUM_CLF-1:0][CLASS_WIDTH-1:0] label_q, label_d;
  logic [NUM_CLF-1:0]                  last_q, last_d;
  logic [DATA_WIDTH-1:0]               out_data_q, out_data_d;
  logic                                out_last_q, out_last_d;
  logic                                mismatch_q, mismatch_d;
  logic [31:0]                         count_q, count_d;

  logic                                load;
  logic                                all_held;
  logic                                out_fire;
  logic [CLASS_WIDTH-1:0]              vote_winner;
  logic [MASK_WIDTH-1:0]               vote_mask;

  assign in_label[0] = s_axis_tdata_0[CLASS_WIDTH-1:0];
  assign in_label[1] = s_axis_tdata_1[CLASS_WIDTH-1:0];
  assign in_label[2] = s_axis_tdata_2[CLASS_WIDTH-1:0];
  assign in_valid    = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
  assign in_last     = {s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};

  // Only the label field of each input beat carries information; tkeep is ignored.
  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2,
                           s_axis_tdata_0[DATA_WIDTH-1:CLASS_WIDTH],
                           s_axis_tdata_1[DATA_WIDTH-1:CLASS_WIDTH],
                           s_axis_tdata_2[DATA_WIDTH-1:CLASS_WIDTH]};

  // A slot can only take a beat when empty, so a held sample is never overwritten.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLF; gi++) begin : g_slot
      assign slot_ready[gi] = rst_n & ~held_q[gi];
      assign accept[gi]     = in_valid[gi] & slot_ready[gi];
    end
  endgenerate

  assign s_axis_tready_0 = slot_ready[0];
  assign s_axis_tready_1 = slot_ready[1];
  assign s_axis_tready_2 = slot_ready[2];

  assign all_held = &held_q;
  assign out_fire = (state_q == OUT) & m_axis_tready;

  majority3_voter #(
    .CLASS_WIDTH (CLASS_WIDTH),
    .TIE_SRC     (TIE_SRC)
  ) u_voter (
    .label_0 (label_q[0]),
    .label_1 (label_q[1]),
    .label_2 (label_q[2]),
    .winner  (vote_winner),
    .mask    (vote_mask)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (all_held) begin
          load    = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_fire) begin
          if (all_held) begin
            load = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    held_d     = held_q;
    label_d    = label_q;
    last_d     = last_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    mismatch_d = mismatch_q;
    count_d    = count_q + {31'd0, out_fire};

    if (load) begin
      held_d                                = '0;
      out_data_d                            = '0;
      out_data_d[CLASS_WIDTH-1:0]           = vote_winner;
      out_data_d[MASK_LSB +: MASK_WIDTH]    = vote_mask;
      out_last_d                            = &last_q;
      if (!all_equal3(last_q[0], last_q[1], last_q[2])) begin
        mismatch_d = 1'b1;
      end
    end

    // load needs every slot held, accept needs it empty, so these never collide.
    for (int i = 0; i < NUM_CLF; i++) begin
      if (accept[i]) begin
        held_d[i]  = 1'b1;
        label_d[i] = in_label[i];
        last_d[i]  = in_last[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      held_q     <= '0;
      label_q    <= '0;
      last_q     <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      mismatch_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      label_q    <= label_d;
      last_q     <= last_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      mismatch_q <= mismatch_d;
      count_q    <= count_d;
    end
  end

  assign m_axis_tvalid  = (state_q == OUT);
  assign m_axis_tdata   = out_data_q;
  assign m_axis_tkeep   = {KEEP_WIDTH{m_axis_tvalid}};
  assign m_axis_tlast   = out_last_q;
  assign tlast_mismatch = mismatch_q;
  assign vote_count     = count_q;

endmodule

// File: tb/tb_ensemble_vote_collector.sv
// Scoreboard bench for ensemble_vote_collector: expected beats are queued as stimulus is
// driven and popped when the DUT completes an output handshake.
module tb_ensemble_vote_collector;

  localparam int DW     = 32;
  localparam int KW     = 4;
  localparam int CW     = 8;
  localparam int TIE    = 0;
  localparam int N_RAND = 1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tdata [3];
  logic [KW-1:0] s_tkeep [3];
  logic [2:0]    s_tvalid;
  logic [2:0]    s_tlast;
  wire  [2:0]    s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          mismatch;
  logic [31:0]   vote_count;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp      = 0;
  int   n_fail     = 0;
  int   votes_seen = 0;
  int   exp_votes  = 0;

  logic [CW-1:0] rnd_lbl  [3][N_RAND];
  logic          rnd_last [3][N_RAND];

  always #5 clk = ~clk;

  ensemble_vote_collector #(
    .DATA_WIDTH  (DW),
    .KEEP_WIDTH  (KW),
    .CLASS_WIDTH (CW),
    .TIE_SRC     (TIE)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis_tdata_0  (s_tdata[0]),
    .s_axis_tkeep_0  (s_tkeep[0]),
    .s_axis_tvalid_0 (s_tvalid[0]),
    .s_axis_tlast_0  (s_tlast[0]),
    .s_axis_tready_0 (s_tready[0]),
    .s_axis_tdata_1  (s_tdata[1]),
    .s_axis_tkeep_1  (s_tkeep[1]),
    .s_axis_tvalid_1 (s_tvalid[1]),
    .s_axis_tlast_1  (s_tlast[1]),
    .s_axis_tready_1 (s_tready[1]),
    .s_axis_tdata_2  (s_tdata[2]),
    .s_axis_tkeep_2  (s_tkeep[2]),
    .s_axis_tvalid_2 (s_tvalid[2]),
    .s_axis_tlast_2  (s_tlast[2]),
    .s_axis_tready_2 (s_tready[2]),
    .m_axis_tdata    (m_tdata),
    .m_axis_tkeep    (m_tkeep),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tready   (m_tready),
    .m_axis_tlast    (m_tlast),
    .tlast_mismatch  (mismatch),
    .vote_count      (vote_count)
  );

  // Reference vote: any label seen at least twice wins, otherwise the tie-source label.
  function automatic logic [DW-1:0] model_vote(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                               input logic [CW-1:0] c);
    logic [CW-1:0] l [3];
    logic [CW-1:0] w;
    logic [DW-1:0] r;
    int            cnt;
    l[0] = a;
    l[1] = b;
    l[2] = c;
    w    = l[TIE];
    for (int i = 0; i < 3; i++) begin
      cnt = 0;
      for (int j = 0; j < 3; j++) if (l[j] == l[i]) cnt++;
      if (cnt >= 2) w = l[i];
    end
    r         = '0;
    r[CW-1:0] = w;
    for (int i = 0; i < 3; i++) r[16+i] = (l[i] == w);
    return r;
  endfunction

  task automatic push_vote(input logic [CW-1:0] a, input logic [CW-1:0] b, input logic [CW-1:0] c,
                           input logic t0, input logic t1, input logic t2);
    exp_t e;
    e.data = model_vote(a, b, c);
    e.last = t0 & t1 & t2;
    exp_q.push_back(e);
    exp_votes++;
  endtask

  // Starts and ends at posedge+1; upper tdata bits and tkeep are random junk.
  task automatic drive_one(input int idx, input logic [CW-1:0] lbl, input logic lst);
    logic [DW-1:0] d;
    logic          hs;
    int            cyc;
    d              = $urandom();
    d[CW-1:0]      = lbl;
    s_tdata[idx]   = d;
    s_tkeep[idx]   = KW'($urandom());
    s_tlast[idx]   = lst;
    s_tvalid[idx]  = 1'b1;
    hs             = 1'b0;
    cyc            = 0;
    while (!hs && cyc < 500) begin
      @(negedge clk);
      hs = s_tready[idx];
      @(posedge clk);
      cyc++;
    end
    #1;
    s_tvalid[idx] = 1'b0;
    if (!hs) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drive_timeout slot=%0d got no tready within 500 cycles, required a handshake", idx);
    end
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout got %0d beats still pending, required 0", exp_q.size());
    end
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (m_tvalid === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL valid_timeout got tvalid=%b, required 1 within 200 cycles", m_tvalid);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    exp_votes = 0;
    exp_q.delete();
  endtask

  task automatic scoreboard_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
        votes_seen++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat got data=%h last=%b, required no beat", m_tdata, m_tlast);
        end else begin
          e = exp_q.pop_front();
          if (m_tdata !== e.data || m_tlast !== e.last || m_tkeep !== {KW{1'b1}}) begin
            n_fail++;
            $display("FAIL scoreboard_beat got data=%h last=%b keep=%h, required data=%h last=%b keep=%h",
                     m_tdata, m_tlast, m_tkeep, e.data, e.last, {KW{1'b1}});
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (s_tready !== 3'b000 || m_tvalid !== 1'b0 || m_tdata !== '0 || m_tkeep !== '0 ||
        m_tlast !== 1'b0 || mismatch !== 1'b0 || vote_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state got ready=%b valid=%b data=%h keep=%h last=%b mm=%b cnt=%0d, required all 0",
               s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, mismatch, vote_count);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (s_tready !== 3'b111 || m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got ready=%b valid=%b, required ready=111 valid=0", s_tready, m_tvalid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    m_tready = 1'b1;
    push_vote(8'd5, 8'd5, 8'd5, 1'b1, 1'b1, 1'b1);
    drive_one(0, 8'd5, 1'b1);
    drive_one(1, 8'd5, 1'b1);
    drive_one(2, 8'd5, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency_early got valid=%b one cycle after last input, required 0", m_tvalid);
    end
    @(negedge clk);
    n_cmp++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h0007_0005 || m_tlast !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_beat got valid=%b data=%h last=%b, required valid=1 data=00070005 last=1",
               m_tvalid, m_tdata, m_tlast);
    end
    wait_idle();
  endtask

  task automatic test_order_tie();
    push_vote(8'd3, 8'd7, 8'd3, 1'b0, 1'b0, 1'b0);
    drive_one(2, 8'd3, 1'b0);
    drive_one(0, 8'd3, 1'b0);
    drive_one(1, 8'd7, 1'b0);
    wait_valid();
    n_cmp++;
    if (m_tdata !== 32'h0005_0003) begin
      n_fail++;
      $display("FAIL order_vote got data=%h, required 00050003", m_tdata);
    end
    @(posedge clk);
    #1;
    push_vote(8'd1, 8'd2, 8'd3, 1'b0, 1'b0, 1'b0);
    drive_one(0, 8'd1, 1'b0);
    drive_one(1, 8'd2, 1'b0);
    drive_one(2, 8'd3, 1'b0);
    wait_valid();
    n_cmp++;
    if (m_tdata !== 32'h0001_0001) begin
      n_fail++;
      $display("FAIL tie_vote got data=%h, required 00010001", m_tdata);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    m_tready = 1'b0;
    do_reset();
    push_vote(8'd4, 8'd4, 8'd6, 1'b0, 1'b0, 1'b0);
    drive_one(0, 8'd4, 1'b0);
    drive_one(1, 8'd4, 1'b0);
    drive_one(2, 8'd6, 1'b0);
    wait_valid();
    @(posedge clk);
    #1;
    push_vote(8'd8, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
    drive_one(2, 8'd1, 1'b0);
    drive_one(1, 8'd1, 1'b0);
    drive_one(0, 8'd8, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (s_tready !== 3'b000) begin
      n_fail++;
      $display("FAIL lookahead_full got ready=%b, required 000", s_tready);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'h0003_0004 || m_tlast !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_stable cycle=%0d got valid=%b data=%h last=%b, required valid=1 data=00030004 last=0",
                 c, m_tvalid, m_tdata, m_tlast);
      end
    end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h0006_0001) begin
      n_fail++;
      $display("FAIL back_to_back got valid=%b data=%h, required valid=1 data=00060001", m_tvalid, m_tdata);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (vote_count !== 32'd2) begin
      n_fail++;
      $display("FAIL b2b_count got %0d, required 2", vote_count);
    end
    wait_idle();
  endtask

  task automatic test_tlast_mismatch();
    n_cmp++;
    if (mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL mismatch_clear got %b, required 0", mismatch);
    end
    push_vote(8'd9, 8'd9, 8'd9, 1'b1, 1'b0, 1'b1);
    drive_one(0, 8'd9, 1'b1);
    drive_one(1, 8'd9, 1'b0);
    drive_one(2, 8'd9, 1'b1);
    wait_valid();
    n_cmp++;
    if (m_tlast !== 1'b0 || m_tdata !== 32'h0007_0009) begin
      n_fail++;
      $display("FAIL mixed_tlast_beat got last=%b data=%h, required last=0 data=00070009", m_tlast, m_tdata);
    end
    wait_idle();
    n_cmp++;
    if (mismatch !== 1'b1) begin
      n_fail++;
      $display("FAIL mismatch_set got %b, required 1", mismatch);
    end
    push_vote(8'd2, 8'd2, 8'd2, 1'b1, 1'b1, 1'b1);
    drive_one(0, 8'd2, 1'b1);
    drive_one(1, 8'd2, 1'b1);
    drive_one(2, 8'd2, 1'b1);
    wait_idle();
    n_cmp++;
    if (mismatch !== 1'b1) begin
      n_fail++;
      $display("FAIL mismatch_sticky got %b, required 1", mismatch);
    end
  endtask

  task automatic test_reset_mid();
    m_tready = 1'b0;
    drive_one(0, 8'd1, 1'b1);
    drive_one(1, 8'd1, 1'b1);
    drive_one(2, 8'd2, 1'b1);
    wait_valid();
    @(posedge clk);
    #1;
    drive_one(0, 8'd4, 1'b1);
    drive_one(1, 8'd4, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (s_tready !== 3'b000) begin
      n_fail++;
      $display("FAIL ready_in_reset got %b, required 000", s_tready);
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    exp_votes = 0;
    exp_q.delete();
    @(negedge clk);
    n_cmp++;
    if (m_tvalid !== 1'b0 || s_tready !== 3'b111 || vote_count !== 32'd0 || mismatch !== 1'b0 ||
        m_tdata !== '0) begin
      n_fail++;
      $display("FAIL mid_reset got valid=%b ready=%b cnt=%0d mm=%b data=%h, required 0 111 0 0 0",
               m_tvalid, s_tready, vote_count, mismatch, m_tdata);
    end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    drive_one(2, 8'd7, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (m_tvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_beat cycle=%0d got valid=%b data=%h, required valid=0", c, m_tvalid, m_tdata);
      end
    end
    @(posedge clk);
    #1;
    push_vote(8'd7, 8'd3, 8'd7, 1'b1, 1'b1, 1'b1);
    drive_one(0, 8'd7, 1'b1);
    drive_one(1, 8'd3, 1'b1);
    wait_idle();
    n_cmp++;
    if (vote_count !== 32'(exp_votes)) begin
      n_fail++;
      $display("FAIL post_reset_count got %0d, required %0d", vote_count, exp_votes);
    end
  endtask

  task automatic drive_stream(input int idx);
    int gap;
    for (int k = 0; k < N_RAND; k++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      drive_one(idx, rnd_lbl[idx][k], rnd_last[idx][k]);
    end
  endtask

  task automatic random_sink(input int target);
    int cyc = 0;
    while (votes_seen < target && cyc < 50000) begin
      @(posedge clk);
      #1;
      m_tready = 1'($urandom_range(0, 1));
      cyc++;
    end
    m_tready = 1'b1;
    if (votes_seen < target) begin
      n_cmp++;
      n_fail++;
      $display("FAIL random_timeout got %0d votes, required %0d", votes_seen, target);
    end
  endtask

  task automatic test_random();
    int   target;
    logic base_last;
    for (int k = 0; k < N_RAND; k++) begin
      base_last = 1'($urandom_range(0, 1));
      for (int s = 0; s < 3; s++) begin
        rnd_lbl[s][k]  = CW'($urandom_range(0, 3));
        rnd_last[s][k] = ($urandom_range(0, 7) == 0) ? ~base_last : base_last;
      end
      push_vote(rnd_lbl[0][k], rnd_lbl[1][k], rnd_lbl[2][k],
                rnd_last[0][k], rnd_last[1][k], rnd_last[2][k]);
    end
    target = votes_seen + N_RAND;
    fork
      drive_stream(0);
      drive_stream(1);
      drive_stream(2);
      random_sink(target);
    join
    wait_idle();
    n_cmp++;
    if (vote_count !== 32'(exp_votes)) begin
      n_fail++;
      $display("FAIL random_count got %0d, required %0d", vote_count, exp_votes);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    m_tready = 1'b0;
    s_tvalid = 3'b000;
    s_tlast  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      s_tdata[i] = '0;
      s_tkeep[i] = '0;
    end
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_basic();
    test_order_tie();
    test_back_to_back();
    test_tlast_mismatch();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
